// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 bits on device clock, ACK check.
// Optional macro PS2_TX_TIMEOUT_EN adds an abort when the device stops clocking for TIMEOUT_CYCLES.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    // state     | meaning
    // IDLE      | waiting for tx_valid, lines released
    // INHIBIT   | holding ps2c low; ps2d pulled low on the final cycle
    // REQ       | ps2c released, start bit on ps2d
    // SEND      | data/parity/stop shifted out on device falling edges
    // ACK       | waiting for the device ACK edge
    // DONE_WAIT | waiting for both lines idle-high before reporting
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] SEND      = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] DONE_WAIT = 3'd5;

    localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W  = (INH_W > TOUT_W) ? INH_W : TOUT_W;
    localparam int FLT_W  = $clog2(FILTER_LEN + 1);

    logic [2:0]       state;
    logic [7:0]       data;
    logic             parity;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic             drive_low;
    logic             ack_ok;
    logic             next_bit;
    logic             tout;

    logic             c_sync1;
    logic             c_sync2;
    logic             d_sync1;
    logic             d_sync2;
    logic             c_filt;
    logic [FLT_W-1:0] flt_cnt;
    logic             flt_hit;
    logic             c_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync1 <= 1'b1;
            c_sync2 <= 1'b1;
            d_sync1 <= 1'b1;
            d_sync2 <= 1'b1;
        end else begin
            c_sync1 <= ps2c_in;
            c_sync2 <= c_sync1;
            d_sync1 <= ps2d_in;
            d_sync2 <= d_sync1;
        end
    end

    // The filtered clock only flips after FILTER_LEN consecutive samples disagree with it.
    assign flt_hit = (c_sync2 != c_filt) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign c_fall  = flt_hit && c_filt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_filt  <= 1'b1;
            flt_cnt <= '0;
        end else if (c_sync2 == c_filt) begin
            flt_cnt <= '0;
        end else if (flt_hit) begin
            c_filt  <= c_sync2;
            flt_cnt <= '0;
        end else begin
            flt_cnt <= flt_cnt + 1'b1;
        end
    end

    always_comb begin
        next_bit = 1'b1;
        if (bit_idx < 4'd8) begin
            next_bit = data[bit_idx[2:0]];
        end else if (bit_idx == 4'd8) begin
            next_bit = parity;
        end
    end

`ifdef PS2_TX_TIMEOUT_EN
    logic frame_active;
    assign frame_active = (state == REQ) || (state == SEND) || (state == ACK) || (state == DONE_WAIT);
    assign tout = frame_active && !c_fall && (cnt == '0);
`else
    assign tout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            data      <= '0;
            parity    <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            drive_low <= 1'b0;
            ack_ok    <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            if (tout) begin
                state     <= IDLE;
                drive_low <= 1'b0;
                bit_idx   <= '0;
                tx_err    <= 1'b1;
            end else begin
`ifdef PS2_TX_TIMEOUT_EN
                if (frame_active) begin
                    cnt <= c_fall ? CNT_W'(TIMEOUT_CYCLES - 1) : cnt - 1'b1;
                end
`endif
                case (state)
                    IDLE: begin
                        if (tx_valid) begin
                            data   <= tx_data;
                            parity <= ~^tx_data;
                            cnt    <= CNT_W'(INHIBIT_CYCLES - 1);
                            state  <= INHIBIT;
                        end
                    end
                    INHIBIT: begin
                        if (cnt == '0) begin
                            state     <= REQ;
                            drive_low <= 1'b1;
                            bit_idx   <= '0;
`ifdef PS2_TX_TIMEOUT_EN
                            cnt       <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    REQ: begin
                        state <= SEND;
                    end
                    SEND: begin
                        if (c_fall) begin
                            drive_low <= ~next_bit;
                            bit_idx   <= bit_idx + 1'b1;
                            if (bit_idx == 4'd9) begin
                                state <= ACK;
                            end
                        end
                    end
                    ACK: begin
                        if (c_fall) begin
                            ack_ok <= ~d_sync2;
                            state  <= DONE_WAIT;
                        end
                    end
                    DONE_WAIT: begin
                        if (c_filt && d_sync2) begin
                            tx_done <= ack_ok;
                            tx_err  <= ~ack_ok;
                            bit_idx <= '0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        drive_low <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign ps2c_oe  = (state == INHIBIT);
    assign ps2d_oe  = ((state == INHIBIT) && (cnt == '0)) ||
                      (((state == REQ) || (state == SEND)) && drive_low);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device model on an open-drain bus, table of frames, random frames, corner sequences.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TOUT = 1000;
    localparam int FILT = 8;
    localparam int HALF = 30;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       dev_clk;
    logic       dev_data;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_acc    = 0;
    int n_viol   = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOUT), .FILTER_LEN(FILT)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    assign ps2c_in = dev_clk & ~ps2c_oe;
    assign ps2d_in = dev_data & ~ps2d_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && tx_valid && tx_ready) n_acc <= n_acc + 1;
    end

    always @(negedge clk) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_err) n_err <= n_err + 1;
        if ((tx_done && tx_err) || (tx_ready == tx_busy)) n_viol <= n_viol + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device side of one host-to-device frame; samples ps2d just before each falling edge.
    task automatic do_frame(input logic [7:0] d, input bit ack, input bit hold, input int glitch_edge,
                            input int abort_edge, output logic [10:0] bits, output int inh_len,
                            output bit ok);
        int t;
        ok = 1'b1;
        bits = '0;
        inh_len = 0;
        t = 0;
        while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
        if (!tx_ready) ok = 1'b0;
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        if (hold) tx_data = ~d;
        else tx_valid = 1'b0;
        while (ps2c_oe && inh_len < INH + 50) begin inh_len++; @(negedge clk); end
        for (int k = 1; k <= 11; k++) begin
            for (int c = 0; c < HALF; c++) begin
                if (k == glitch_edge && c == 15) dev_clk = 1'b0;
                if (k == glitch_edge && c == 18) dev_clk = 1'b1;
                @(negedge clk);
            end
            bits[k-1] = ps2d_in;
            if (k == 11 && ack) dev_data = 1'b0;
            repeat (2) @(negedge clk);
            dev_clk = 1'b0;
            if (k == 11) tx_valid = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == abort_edge) return;
            dev_clk = 1'b1;
        end
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
        t = 0;
        while (!tx_ready && t < 200) begin @(negedge clk); t++; end
        if (!tx_ready) ok = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        bit          ack;
        bit          hold;
        int          glitch;
        logic [10:0] exp_bits;
        bit          exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic run_and_check(input string tag, input logic [7:0] d, input bit ack, input bit hold,
                                 input int glitch, input logic [10:0] exp_bits, input bit exp_done);
        logic [10:0] bits;
        int inh_len;
        bit ok;
        int s_done, s_err, s_acc;
        s_done = n_done;
        s_err = n_err;
        s_acc = n_acc;
        do_frame(d, ack, hold, glitch, 0, bits, inh_len, ok);
        repeat (3) @(negedge clk);
        check({tag, "_completed"}, 32'(ok), 32'd1);
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_inhibit_len"}, inh_len, INH);
        check({tag, "_done_pulses"}, n_done - s_done, exp_done ? 1 : 0);
        check({tag, "_err_pulses"}, n_err - s_err, exp_done ? 0 : 1);
        check({tag, "_accepts"}, n_acc - s_acc, 1);
    endtask

    initial begin
        logic [10:0] bits;
        logic [10:0] exp_bits;
        logic [7:0]  d;
        int inh_len;
        int s_done, s_err, n, t;
        bit ok, ack, par;

        vecs[0] = '{8'hED, 1'b1, 1'b1, 0, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b1};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 0, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0, 4, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 0, {1'b1, 1'b0, 8'h07, 1'b0}, 1'b1};
        vecs[4] = '{8'h80, 1'b0, 1'b0, 7, {1'b1, 1'b0, 8'h80, 1'b0}, 1'b0};

        reset = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_ps2c_oe", 32'(ps2c_oe), 32'd0);
        check("rst_ps2d_oe", 32'(ps2d_oe), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        dev_clk = 1'b0;
        repeat (25) @(negedge clk);
        dev_clk = 1'b1;
        repeat (25) @(negedge clk);
        check("idle_edge_busy", 32'(tx_busy), 32'd0);
        check("idle_edge_pulses", n_done + n_err, 0);

        for (int i = 0; i < 5; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack, vecs[i].hold,
                          vecs[i].glitch, vecs[i].exp_bits, vecs[i].exp_done);
        end

        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom_range(0, 255));
            ack = 1'($urandom_range(0, 1));
            par = ($countones(d) % 2) == 0;
            exp_bits = {1'b1, par, d, 1'b0};
            run_and_check($sformatf("rnd%0d", i), d, ack, 1'b0, $urandom_range(0, 11), exp_bits, ack);
        end

        // Reset in the middle of a frame while ps2d is being driven low (0xA5 bit 3 = 0).
        s_done = n_done;
        s_err = n_err;
        do_frame(8'hA5, 1'b1, 1'b0, 0, 4, bits, inh_len, ok);
        check("abort_predrive_ps2d", 32'(ps2d_oe), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_ps2c_oe", 32'(ps2c_oe), 32'd0);
        check("abort_ps2d_oe", 32'(ps2d_oe), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_done", n_done - s_done, 0);
        check("abort_no_err", n_err - s_err, 0);
        run_and_check("post_abort_ff", 8'hFF, 1'b1, 1'b0, 0, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b1);

`ifdef PS2_TX_TIMEOUT_EN
        s_done = n_done;
        t = 0;
        while (!tx_ready && t < 2000) begin @(negedge clk); t++; end
        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        t = 0;
        while (ps2c_oe && t < INH + 50) begin t++; @(negedge clk); end
        n = 0;
        while (!tx_err && n < TOUT + 100) begin n++; @(negedge clk); end
        check("timeout_cycles", n, TOUT);
        check("timeout_ps2c_oe", 32'(ps2c_oe), 32'd0);
        check("timeout_ps2d_oe", 32'(ps2d_oe), 32'd0);
        check("timeout_ready", 32'(tx_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("timeout_no_done", n_done - s_done, 0);
`endif

        repeat (3) @(negedge clk);
        check("protocol_violations", n_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
